// File: rtl/safety_monitor_nch.sv
// Multi-channel laser pulse safety monitor: per-channel width/period limit checks with sticky fail flags.
// Define SAFETY_MON_FIRST_FAIL_EN to build the first-failing-channel capture.
module safety_monitor_nch #(
    parameter int NCH         = 4,
    parameter int CW          = 32,
    parameter int SYNC_STAGES = 2,
    localparam int FW         = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [NCH-1:0] laser_pulse,
    input  logic          laser_ready,
    input  logic          enable_check,
    input  logic          clear_fail,
    input  logic [CW-1:0] pulse_width_lower_limit,
    input  logic [CW-1:0] pulse_width_upper_limit,
    input  logic [CW-1:0] rate_lower_limit,
    output logic [NCH-1:0] pulse_lower_limit_fail,
    output logic [NCH-1:0] pulse_upper_limit_fail,
    output logic [NCH-1:0] rate_lower_limit_fail,
    output logic          any_fail,
    output logic          shutdown,
    output logic          first_fail_valid,
    output logic [FW-1:0] first_fail_ch
);

    localparam logic [CW-1:0] SAT = '1;

    logic [SYNC_STAGES-1:0] sync [NCH];
    logic [CW-1:0]          w    [NCH];
    logic [CW-1:0]          r    [NCH];
    logic [NCH-1:0]         s, p, seen_rise, armed;
    logic [NCH-1:0]         rise, fall;
    logic [NCH-1:0]         set_lo, set_up, set_rt;
    logic [NCH-1:0]         lo_next, up_next, rt_next;
    logic [SYNC_STAGES:0]   fill;
    logic                   active, run, any_next;

    // After reset the synchronisers and p hold stale zeros; edges are ignored until p
    // holds a real sample, so a line already high at release is not seen as a rise.
    assign active = fill[SYNC_STAGES];
    assign run    = laser_ready & active;

    always_comb begin
        s      = '0;
        set_lo = '0;
        set_up = '0;
        set_rt = '0;
        for (int i = 0; i < NCH; i++) begin
            s[i] = sync[i][SYNC_STAGES-1];
        end
        rise = s & ~p;
        fall = ~s & p;
        for (int i = 0; i < NCH; i++) begin
            set_lo[i] = run & fall[i] & seen_rise[i] & (w[i] < pulse_width_lower_limit);
            set_up[i] = run & s[i] & ~rise[i] & (pulse_width_upper_limit != '0)
                        & (w[i] >= pulse_width_upper_limit);
            set_rt[i] = run & rise[i] & armed[i] & (r[i] < rate_lower_limit);
        end
        lo_next  = set_lo | (pulse_lower_limit_fail & ~{NCH{clear_fail}});
        up_next  = set_up | (pulse_upper_limit_fail & ~{NCH{clear_fail}});
        rt_next  = set_rt | (rate_lower_limit_fail  & ~{NCH{clear_fail}});
        any_next = |{lo_next, up_next, rt_next};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fill      <= '0;
            p         <= '0;
            seen_rise <= '0;
            armed     <= '0;
            for (int i = 0; i < NCH; i++) begin
                sync[i] <= '0;
                w[i]    <= '0;
                r[i]    <= '0;
            end
        end else begin
            fill <= {fill[SYNC_STAGES-1:0], 1'b1};
            p    <= s;
            for (int i = 0; i < NCH; i++) begin
                sync[i] <= {sync[i][SYNC_STAGES-2:0], laser_pulse[i]};
                if (!run) begin
                    w[i]         <= '0;
                    r[i]         <= '0;
                    seen_rise[i] <= 1'b0;
                    armed[i]     <= 1'b0;
                end else if (rise[i]) begin
                    w[i]         <= {{(CW-1){1'b0}}, 1'b1};
                    r[i]         <= {{(CW-1){1'b0}}, 1'b1};
                    seen_rise[i] <= 1'b1;
                    armed[i]     <= 1'b1;
                end else begin
                    if (s[i] && w[i] != SAT) begin
                        w[i] <= w[i] + 1'b1;
                    end
                    if (r[i] != SAT) begin
                        r[i] <= r[i] + 1'b1;
                    end
                end
            end
        end
    end

    // A new violation in the same cycle as clear_fail keeps its flag set.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pulse_lower_limit_fail <= '0;
            pulse_upper_limit_fail <= '0;
            rate_lower_limit_fail  <= '0;
        end else begin
            pulse_lower_limit_fail <= lo_next;
            pulse_upper_limit_fail <= up_next;
            rate_lower_limit_fail  <= rt_next;
        end
    end

    assign any_fail = |{pulse_lower_limit_fail, pulse_upper_limit_fail, rate_lower_limit_fail};
    assign shutdown = any_fail & enable_check;

`ifdef SAFETY_MON_FIRST_FAIL_EN
    logic [NCH-1:0] set_any;
    logic [FW-1:0]  ff_idx;
    logic           ff_trig;

    // Descending scan so the lowest-index offender is the one left in ff_idx.
    always_comb begin
        set_any = set_lo | set_up | set_rt;
        ff_idx  = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (set_any[i]) begin
                ff_idx = FW'(i);
            end
        end
        ff_trig = ~any_fail & any_next;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            first_fail_valid <= 1'b0;
            first_fail_ch    <= '0;
        end else if (ff_trig) begin
            first_fail_valid <= 1'b1;
            first_fail_ch    <= ff_idx;
        end else if (clear_fail) begin
            first_fail_valid <= 1'b0;
            first_fail_ch    <= '0;
        end
    end
`else
    assign first_fail_valid = 1'b0;
    assign first_fail_ch    = '0;
`endif

endmodule
